sa_array_ctrl: RTL and testbench
================================

Name: sa_array_ctrl

Overview:
- Sequencer for an N x N output-stationary systolic array of PEs.
- Accepts a start command with inner dimension k, clears the array, then drives pe_enable and per-row/per-column skewed feed masks and step index for the operand feeders.
- After the last accumulate, hands results out row by row over a valid/ready port.
- Sits between the host command interface and the PE grid plus its edge feeders.

Parameters:
N, 4, array dimension (rows = cols); N >= 2
KMAX, 16, maximum supported inner dimension k
KW, $clog2(KMAX+1), width of k_len
SW, $clog2(KMAX+2*N), width of feed_step

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  command strobe; accepted only in IDLE
k_len  in  KW  inner dimension, sampled when start is accepted
abort  in  1  synchronous abort, returns to IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last result row is read
pe_clear_n  out  1  active-low clear to the array's reset input
pe_enable  out  1  array-wide enable
feed_step  out  SW  current skew step t during FEED
row_mask  out  N  row_mask[i]=1: A feeder row i drives A[i][t-i], else drives 0
col_mask  out  N  col_mask[j]=1: B feeder col j drives B[t-j][j], else drives 0
rd_valid  out  1  result row available
rd_row  out  $clog2(N)  index of the result row being presented
rd_ready  in  1  consumer accepts the row

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, pe_enable=0, feed_step=0, row_mask=0, col_mask=0, rd_valid=0, rd_row=0, pe_clear_n=0 (array held clear during reset).
- In IDLE after reset: pe_clear_n=1.
- States: IDLE -> CLEAR -> FEED -> READ -> DONE -> IDLE.
- IDLE: start=1 latches k_eff = min(k_len, KMAX) and goes to CLEAR next cycle. start is ignored in every other state.
- CLEAR: exactly 1 cycle; pe_clear_n=0, pe_enable=0.
  - k_eff=0: next state READ (array results all 0).
  - Otherwise: next state FEED with t=0.
- FEED: pe_enable=1; t runs 0 .. k_eff+2N-3, for k_eff+2N-2 cycles total, then READ.
  - feed_step=t.
  - row_mask[i] = (t>=i) && (t-i<k_eff).
  - col_mask[j] = (t>=j) && (t-j<k_eff).
  - Masks are combinational from registered t and k_eff.
- READ: pe_enable=0 (results hold); rd_valid=1; rd_row starts at 0.
  - rd_valid && rd_ready advances rd_row.
  - Handshake on rd_row=N-1 moves to DONE.
  - rd_valid && !rd_ready holds rd_row (stall).
- DONE: done=1 for 1 cycle, busy=1, then IDLE.
- Outside FEED: feed_step=0 and masks=0.
- abort=1 in any non-IDLE state: IDLE next cycle, no done pulse, pe_enable drops the same edge, rd_valid=0.
  - Array contents are not cleared on abort; the next command's CLEAR handles that.
  - abort has priority over a rd_ready handshake in the same cycle.
- start and abort together in IDLE: abort has no effect, start is accepted.
- Latency, start to done: 1 (CLEAR) + (k_eff+2N-2) + N (with rd_ready held high) + 1 cycles; k_eff=0 gives 1+N+1.
- Asserting rst_n=0 mid-operation forces reset values immediately.

Optional Feature:
- Macro SA_CTRL_PERF_EN.
- Defined:
  - Adds 32-bit outputs perf_busy_cyc and perf_stall_cyc.
  - perf_busy_cyc counts cycles with busy=1.
  - perf_stall_cyc counts cycles in READ with rd_ready=0.
  - Both saturate at 2^32-1, reset to 0 on rst_n, and clear on accepted start.
- Undefined: both ports exist and are tied to 0, so the port list is stable.

Test Plan:
- N=4, start with k_len=3, rd_ready=1 → CLEAR 1 cycle; pe_enable high exactly 9 cycles; at t=4 row_mask=4'b1100 and col_mask=4'b1100; rd_row 0,1,2,3 on consecutive cycles; done at cycle 15 after start.
- N=4, k_len=0 → CLEAR, then READ immediately; pe_enable never high; done 6 cycles after start.
- k_len=20 with KMAX=16 → FEED lasts 22 cycles (clamped to 16).
- READ with rd_ready low for 3 cycles on row 2 → rd_row holds 2; done delayed 3 cycles; with SA_CTRL_PERF_EN, perf_stall_cyc=3.
- abort at t=5 in FEED → next cycle IDLE, busy=0, pe_enable=0, no done; a new start with k=2 runs cleanly starting with CLEAR.
- rst_n pulsed low in READ → outputs take reset values asynchronously; pe_clear_n=0 while low; start ignored during FEED of a following run.

Source files
------------

// File: rtl/sa_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sa_array_ctrl
// Brief    : Sequencer for an N x N output-stationary systolic array. It clears
//            the array, drives the skewed operand feed, then reads out rows.
//            Define SA_CTRL_PERF_EN to enable the busy/stall performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module sa_array_ctrl #(
    parameter int N    = 4,
    parameter int KMAX = 16,
    parameter int KW   = $clog2(KMAX + 1),
    parameter int SW   = $clog2(KMAX + 2 * N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 pe_clear_n,
    output logic                 pe_enable,
    output logic [SW-1:0]        feed_step,
    output logic [N-1:0]         row_mask,
    output logic [N-1:0]         col_mask,
    output logic                 rd_valid,
    output logic [$clog2(N)-1:0] rd_row,
    input  logic                 rd_ready,
    output logic [31:0]          perf_busy_cyc,
    output logic [31:0]          perf_stall_cyc
);

    localparam int RW = $clog2(N);
    localparam int WW = SW + 1;

    localparam logic [KW-1:0] c_kmax     = KW'(KMAX);
    localparam logic [WW-1:0] c_tail     = WW'(2 * N - 3);
    localparam logic [RW-1:0] c_row_last = RW'(N - 1);
    localparam logic [RW-1:0] c_row_one  = RW'(1);
    localparam logic [SW-1:0] c_t_one    = SW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_READ  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [KW-1:0]   r_k_eff;
    logic [SW-1:0]   r_t;
    logic [RW-1:0]   r_rd_row;
    logic            r_pe_clear_n;
    logic            w_accept;
    logic [WW-1:0]   w_t_ext;
    logic [WW-1:0]   w_k_ext;
    logic            w_feed_last;
    logic [N-1:0]    w_mask;

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_t_ext     = {1'b0, r_t};
    assign w_k_ext     = WW'(r_k_eff);
    assign w_feed_last = (w_t_ext == (w_k_ext + c_tail));

    // Row and column skews are identical, so one mask serves both feeders.
    for (genvar i = 0; i < N; i++) begin : g_mask
        localparam logic [WW-1:0] c_i = WW'(i);
        assign w_mask[i] = (w_t_ext >= c_i) && ((w_t_ext - c_i) < w_k_ext);
    end

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        pe_enable    = 1'b0;
        feed_step    = '0;
        row_mask     = '0;
        col_mask     = '0;
        rd_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_CLEAR;
            end
            S_CLEAR: begin
                w_state_next = (r_k_eff == '0) ? S_READ : S_FEED;
            end
            S_FEED: begin
                pe_enable = 1'b1;
                feed_step = r_t;
                row_mask  = w_mask;
                col_mask  = w_mask;
                if (w_feed_last) w_state_next = S_READ;
            end
            S_READ: begin
                rd_valid = 1'b1;
                if (rd_ready && (r_rd_row == c_row_last)) w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        // Abort wins over any handshake; in IDLE it is ignored so start still lands.
        if (abort && (r_state != S_IDLE)) w_state_next = S_IDLE;
    end

    assign rd_row     = r_rd_row;
    assign pe_clear_n = r_pe_clear_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_k_eff      <= '0;
            r_t          <= '0;
            r_rd_row     <= '0;
            r_pe_clear_n <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pe_clear_n <= (w_state_next != S_CLEAR);
            if (w_accept) r_k_eff <= (k_len > c_kmax) ? c_kmax : k_len;
            if ((r_state == S_FEED) && (w_state_next == S_FEED)) r_t <= r_t + c_t_one;
            else r_t <= '0;
            if ((r_state == S_READ) && (w_state_next == S_READ)) begin
                if (rd_ready) r_rd_row <= r_rd_row + c_row_one;
            end else begin
                r_rd_row <= '0;
            end
        end
    end

`ifdef SA_CTRL_PERF_EN
    logic [31:0] r_perf_busy;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else if (w_accept) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if ((r_state != S_IDLE) && (r_perf_busy != '1)) r_perf_busy <= r_perf_busy + 32'd1;
            if ((r_state == S_READ) && !rd_ready && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_busy_cyc  = r_perf_busy;
    assign perf_stall_cyc = r_perf_stall;
`else
    assign perf_busy_cyc  = '0;
    assign perf_stall_cyc = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sa_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_array_ctrl
// Brief    : Self-checking bench for sa_array_ctrl with a result-row scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sa_array_ctrl;

    localparam int N    = 4;
    localparam int KMAX = 16;
    localparam int KW   = $clog2(KMAX + 1);
    localparam int SW   = $clog2(KMAX + 2 * N);
    localparam int RW   = $clog2(N);

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic [KW-1:0] k_len    = '0;
    logic          abort    = 1'b0;
    logic          rd_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          pe_clear_n;
    logic          pe_enable;
    logic [SW-1:0] feed_step;
    logic [N-1:0]  row_mask;
    logic [N-1:0]  col_mask;
    logic          rd_valid;
    logic [RW-1:0] rd_row;
    logic [31:0]   perf_busy_cyc;
    logic [31:0]   perf_stall_cyc;

    int checks   = 0;
    int failures = 0;
    int sb_q[$];

    always #5 clk = ~clk;

    sa_array_ctrl #(.N(N), .KMAX(KMAX)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .k_len          (k_len),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .pe_clear_n     (pe_clear_n),
        .pe_enable      (pe_enable),
        .feed_step      (feed_step),
        .row_mask       (row_mask),
        .col_mask       (col_mask),
        .rd_valid       (rd_valid),
        .rd_row         (rd_row),
        .rd_ready       (rd_ready),
        .perf_busy_cyc  (perf_busy_cyc),
        .perf_stall_cyc (perf_stall_cyc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one command and observes it to completion; result rows are scored
    // against the expected order pushed when the command is issued.
    task automatic run_cmd(input int k, input int stall_row, input int stall_len,
                           input bit poke_start, input bit abort_with_start,
                           output bit clr_first, output int clr_cyc, output int en_cyc,
                           output int done_cyc, output logic [N-1:0] rm4,
                           output logic [N-1:0] cm4);
        int cyc;
        int stalled;
        int exp_row;
        clr_cyc  = 0;
        en_cyc   = 0;
        done_cyc = -1;
        rm4      = 'x;
        cm4      = 'x;
        stalled  = 0;
        for (int r = 0; r < N; r++) sb_q.push_back(r);
        start    = 1'b1;
        k_len    = KW'(k);
        abort    = abort_with_start;
        rd_ready = 1'b1;
        tick();
        start     = 1'b0;
        abort     = 1'b0;
        cyc       = 1;
        clr_first = !pe_clear_n;
        while (cyc <= 200) begin
            if (!pe_clear_n) clr_cyc++;
            if (pe_enable) en_cyc++;
            if (pe_enable && (feed_step == SW'(4))) begin
                rm4 = row_mask;
                cm4 = col_mask;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            start = poke_start && pe_enable;
            k_len = (poke_start && pe_enable) ? KW'(7) : KW'(k);
            if (rd_valid && (rd_row == RW'(stall_row)) && (stalled < stall_len)) begin
                rd_ready = 1'b0;
                stalled++;
            end else begin
                rd_ready = 1'b1;
            end
            if (rd_valid && rd_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_row unexpected handshake got=%0d expected=none", rd_row);
                end else begin
                    exp_row = sb_q.pop_front();
                    if (rd_row !== RW'(exp_row)) begin
                        failures++;
                        $display("FAIL sb_row got=%0d expected=%0d", rd_row, exp_row);
                    end
                end
            end
            tick();
            cyc++;
        end
        start    = 1'b0;
        rd_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, done, pe_enable, rd_valid, pe_clear_n} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b expected=00000", {busy, done, pe_enable, rd_valid, pe_clear_n});
        end
        checks++;
        if ({feed_step, row_mask, col_mask, rd_row} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h expected=0", {feed_step, row_mask, col_mask, rd_row});
        end
        checks++;
        if ({perf_busy_cyc, perf_stall_cyc} !== 64'd0) begin
            failures++;
            $display("FAIL reset_perf got=%0d/%0d expected=0/0", perf_busy_cyc, perf_stall_cyc);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({pe_clear_n, busy} !== 2'b10) begin
            failures++;
            $display("FAIL idle_after_reset got=%b expected=10", {pe_clear_n, busy});
        end
    endtask

    task automatic test_basic();
        bit cf; int cc, ec, dc; logic [N-1:0] rm, cm;
        run_cmd(3, 0, 0, 1'b0, 1'b0, cf, cc, ec, dc, rm, cm);
        checks++;
        if (!(cf && cc == 1)) begin
            failures++;
            $display("FAIL basic_clear got=%0d/%0d expected=1/1", cf, cc);
        end
        checks++;
        if (ec != 9) begin failures++; $display("FAIL basic_enable got=%0d expected=9", ec); end
        checks++;
        if ({rm, cm} !== 8'b1100_1100) begin
            failures++;
            $display("FAIL basic_masks_t4 got=%b/%b expected=1100/1100", rm, cm);
        end
        checks++;
        if (dc != 15) begin failures++; $display("FAIL basic_done got=%0d expected=15", dc); end
        checks++;
        if ((sb_q.size() != 0) || busy) begin
            failures++;
            $display("FAIL basic_drain got=%0d/%0d expected=0/0", sb_q.size(), busy);
        end
`ifdef SA_CTRL_PERF_EN
        checks++;
        if ({perf_busy_cyc, perf_stall_cyc} !== {32'd15, 32'd0}) begin
            failures++;
            $display("FAIL basic_perf got=%0d/%0d expected=15/0", perf_busy_cyc, perf_stall_cyc);
        end
`endif
    endtask

    task automatic test_k_zero();
        bit cf; int cc, ec, dc; logic [N-1:0] rm, cm;
        run_cmd(0, 0, 0, 1'b0, 1'b0, cf, cc, ec, dc, rm, cm);
        checks++;
        if (!(cf && cc == 1 && ec == 0)) begin
            failures++;
            $display("FAIL kzero_clear_en got=%0d/%0d/%0d expected=1/1/0", cf, cc, ec);
        end
        checks++;
        if (dc != 6) begin failures++; $display("FAIL kzero_done got=%0d expected=6", dc); end
    endtask

    task automatic test_clamp();
        bit cf; int cc, ec, dc; logic [N-1:0] rm, cm;
        run_cmd(20, 0, 0, 1'b0, 1'b0, cf, cc, ec, dc, rm, cm);
        checks++;
        if (ec != 22) begin failures++; $display("FAIL clamp_enable got=%0d expected=22", ec); end
        checks++;
        if (dc != 28) begin failures++; $display("FAIL clamp_done got=%0d expected=28", dc); end
    endtask

    task automatic test_stall();
        bit cf; int cc, ec, dc; logic [N-1:0] rm, cm;
        run_cmd(3, 2, 3, 1'b0, 1'b0, cf, cc, ec, dc, rm, cm);
        checks++;
        if (dc != 18) begin failures++; $display("FAIL stall_done got=%0d expected=18", dc); end
        checks++;
        if (sb_q.size() != 0) begin failures++; $display("FAIL stall_drain got=%0d expected=0", sb_q.size()); end
`ifdef SA_CTRL_PERF_EN
        checks++;
        if ({perf_busy_cyc, perf_stall_cyc} !== {32'd18, 32'd3}) begin
            failures++;
            $display("FAIL stall_perf got=%0d/%0d expected=18/3", perf_busy_cyc, perf_stall_cyc);
        end
`endif
    endtask

    task automatic test_abort();
        bit cf; int cc, ec, dc; logic [N-1:0] rm, cm;
        int n;
        int dones;
        start    = 1'b1;
        k_len    = KW'(3);
        rd_ready = 1'b1;
        tick();
        start = 1'b0;
        n     = 0;
        while (!(pe_enable && feed_step == SW'(5)) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 50) begin failures++; $display("FAIL abort_reach_t5 got=timeout expected=t5"); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({busy, pe_enable, rd_valid} !== 3'b000) begin
            failures++;
            $display("FAIL abort_idle got=%b expected=000", {busy, pe_enable, rd_valid});
        end
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (done || busy) dones++;
            tick();
        end
        checks++;
        if (dones != 0) begin failures++; $display("FAIL abort_no_done got=%0d expected=0", dones); end
        run_cmd(2, 0, 0, 1'b0, 1'b0, cf, cc, ec, dc, rm, cm);
        checks++;
        if (!(cf && cc == 1 && ec == 8 && dc == 14)) begin
            failures++;
            $display("FAIL abort_rerun got=%0d/%0d/%0d/%0d expected=1/1/8/14", cf, cc, ec, dc);
        end
    endtask

    task automatic test_start_abort_idle();
        bit cf; int cc, ec, dc; logic [N-1:0] rm, cm;
        run_cmd(1, 0, 0, 1'b0, 1'b1, cf, cc, ec, dc, rm, cm);
        checks++;
        if (!(cf && dc == 13)) begin
            failures++;
            $display("FAIL start_abort_idle got=%0d/%0d expected=1/13", cf, dc);
        end
    endtask

    task automatic test_async_reset();
        bit cf; int cc, ec, dc; logic [N-1:0] rm, cm;
        int n;
        start    = 1'b1;
        k_len    = KW'(1);
        rd_ready = 1'b1;
        tick();
        start = 1'b0;
        n     = 0;
        while (!(rd_valid && rd_row == RW'(1)) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 50) begin failures++; $display("FAIL areset_reach_read got=timeout expected=row1"); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, pe_enable, rd_valid, pe_clear_n, rd_row} !== '0) begin
            failures++;
            $display("FAIL areset_immediate got=%b expected=0", {busy, done, pe_enable, rd_valid, pe_clear_n, rd_row});
        end
        sb_q.delete();
        tick();
        tick();
        checks++;
        if ({pe_clear_n, busy, perf_busy_cyc} !== '0) begin
            failures++;
            $display("FAIL areset_held got=%b/%b/%0d expected=0/0/0", pe_clear_n, busy, perf_busy_cyc);
        end
        rst_n = 1'b1;
        tick();
        run_cmd(2, 0, 0, 1'b1, 1'b0, cf, cc, ec, dc, rm, cm);
        checks++;
        if (!(cf && ec == 8 && dc == 14)) begin
            failures++;
            $display("FAIL areset_rerun_poke got=%0d/%0d/%0d expected=1/8/14", cf, ec, dc);
        end
        checks++;
        if (busy || sb_q.size() != 0) begin
            failures++;
            $display("FAIL areset_final got=%0d/%0d expected=0/0", busy, sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_k_zero();
        test_clamp();
        test_stall();
        test_abort();
        test_start_abort_idle();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
